// File: rtl/usr_pkg.sv
// usr_pkg: mode encodings and widths shared by the universal shift register files
package usr_pkg;
  localparam int MODE_W = 3;
  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b101;
  localparam logic [MODE_W-1:0] MODE_ASR  = 3'b110;
  localparam logic [MODE_W-1:0] MODE_CLR  = 3'b111;
endpackage

// File: rtl/usr_cell.sv
// usr_cell: one register bit with asynchronous active-high reset to a per-bit value
module usr_cell (
  input  logic clk,
  input  logic rst,
  input  logic rst_val_i,
  input  logic d_i,
  output logic q_o,
  output logic qb_o
);
  logic q_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) q_q <= rst_val_i;
    else     q_q <= d_i;
  assign q_o  = q_q;
  assign qb_o = ~q_q;
endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal shift register with complementary outputs.
// Rotate modes are built only when USR_ROTATE_EN is defined; otherwise they hold.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              si_msb,
  input  logic              si_lsb,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  qb,
  output logic              so_msb,
  output logic              so_lsb
);
  // One-bit-wider views keep every shift a plain slice, including WIDTH=1
  logic [WIDTH:0] shr_w, shl_w, asr_w;
  logic [WIDTH-1:0] nxt_d;
  assign shr_w = {si_msb, q};
  assign shl_w = {q, si_lsb};
  assign asr_w = {q[WIDTH-1], q};
`ifdef USR_ROTATE_EN
  logic [WIDTH:0] ror_w, rol_w;
  assign ror_w = {q[0], q};
  assign rol_w = {q, q[WIDTH-1]};
`endif
  always_comb begin
    nxt_d = q;
    if (en)
      case (mode)
        MODE_SHR:  nxt_d = shr_w[WIDTH:1];
        MODE_SHL:  nxt_d = shl_w[WIDTH-1:0];
        MODE_LOAD: nxt_d = d;
`ifdef USR_ROTATE_EN
        MODE_ROR:  nxt_d = ror_w[WIDTH:1];
        MODE_ROL:  nxt_d = rol_w[WIDTH-1:0];
`endif
        MODE_ASR:  nxt_d = asr_w[WIDTH:1];
        MODE_CLR:  nxt_d = '0;
        default:   nxt_d = q;
      endcase
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    usr_cell u_cell (
      .clk       (clk),
      .rst       (rst),
      .rst_val_i (RST_VAL[i]),
      .d_i       (nxt_d[i]),
      .q_o       (q[i]),
      .qb_o      (qb[i])
    );
  end
  assign so_msb = q[WIDTH-1];
  assign so_lsb = q[0];
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed stimulus on 8-bit and 1-bit instances against an arithmetic model
module tb_univ_shift_reg;
  import usr_pkg::*;
  logic clk = 0, rst = 0, en = 0, si_msb = 0, si_lsb = 0, run = 0;
  logic [2:0] mode = MODE_HOLD;
  logic [7:0] d = 0;
  logic [7:0] q8, qb8, m8, nb8;
  logic q1, qb1, som1, sol1, som8, sol8, m1, nb1;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(8), .RST_VAL(8'hA5)) dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .si_msb(si_msb), .si_lsb(si_lsb),
    .q(q8), .qb(qb8), .so_msb(som8), .so_lsb(sol8));
  univ_shift_reg #(.WIDTH(1), .RST_VAL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d[0]), .si_msb(si_msb), .si_lsb(si_lsb),
    .q(q1), .qb(qb1), .so_msb(som1), .so_lsb(sol1));

  function automatic logic [7:0] nxt8(input logic [2:0] m, input logic [7:0] v, dv, input logic sm, sl);
    case (m)
      3'd1: return (v >> 1) | (8'(sm) << 7);
      3'd2: return (v << 1) | 8'(sl);
      3'd3: return dv;
`ifdef USR_ROTATE_EN
      3'd4: return (v >> 1) | (v << 7);
      3'd5: return (v << 1) | (v >> 7);
`endif
      3'd6: return 8'($signed(v) >>> 1);
      3'd7: return 8'h00;
      default: return v;
    endcase
  endfunction

  function automatic logic nxt1(input logic [2:0] m, input logic v, dv, sm, sl);
    case (m)
      3'd1: return sm;
      3'd2: return sl;
      3'd3: return dv;
      3'd7: return 1'b0;
      default: return v;
    endcase
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) begin
      m8 <= 8'hA5;
      m1 <= 1'b0;
    end else if (en) begin
      m8 <= nxt8(mode, m8, d, si_msb, si_lsb);
      m1 <= nxt1(mode, m1, d[0], si_msb, si_lsb);
    end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) if (run) begin
    nb8 = ~m8;
    nb1 = ~m1;
    chk("model_q8", q8, m8);
    chk("model_qb8", qb8, nb8);
    chk("model_som8", som8, m8[7]);
    chk("model_sol8", sol8, m8[0]);
    chk("model_q1", q1, m1);
    chk("model_qb1", qb1, nb1);
    chk("model_so1", {som1, sol1}, {m1, m1});
  end

  task automatic step(input logic [2:0] m, input logic e, input logic [7:0] dv, input logic sm, input logic sl);
    mode = m; en = e; d = dv; si_msb = sm; si_lsb = sl;
    @(posedge clk); #1;
  endtask

  initial begin
    #1 rst = 1;
    @(posedge clk); #1;
    run = 1;
    chk("rst_q", q8, 8'hA5);
    chk("rst_qb", qb8, 8'h5A);
    chk("rst_so", {som8, sol8}, 2'b11);
    rst = 0;
    step(MODE_SHR, 0, 8'h00, 1, 1);
    chk("release_hold", q8, 8'hA5);
    step(MODE_LOAD, 1, 8'h3C, 0, 0);
    chk("load_3c", q8, 8'h3C);
    #2 rst = 1;
    #1 chk("async_rst_q", q8, 8'hA5);
    chk("async_rst_qb", qb8, 8'h5A);
    rst = 0;
    step(MODE_LOAD, 1, 8'h3C, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(MODE_SHR, 0, 8'hFF, 1, 1);
      chk("en0_hold_q", q8, 8'h3C);
      chk("en0_hold_qb", qb8, 8'hC3);
    end
    step(MODE_LOAD, 1, 8'h81, 0, 0);
    step(MODE_SHR, 1, 8'h00, 1, 1);
    chk("shr_c0", q8, 8'hC0);
    step(MODE_SHL, 1, 8'h00, 1, 0);
    chk("shl_80", q8, 8'h80);
    step(MODE_ASR, 1, 8'h00, 0, 0);
    chk("asr_c0", q8, 8'hC0);
    step(MODE_LOAD, 1, 8'h81, 0, 0);
    step(MODE_ROR, 1, 8'h00, 0, 0);
`ifdef USR_ROTATE_EN
    chk("ror_c0", q8, 8'hC0);
`else
    chk("ror_off_hold", q8, 8'h81);
`endif
    step(MODE_ROL, 1, 8'h00, 0, 0);
    chk("rol_81", q8, 8'h81);
    mode = 3'bxxx; en = 1;
    @(posedge clk); #1;
    chk("xmode_hold", q8, 8'h81);
    step(MODE_LOAD, 1, 8'hFF, 0, 0);
    step(MODE_CLR, 1, 8'h00, 0, 0);
    chk("clr_00", q8, 8'h00);
    mode = MODE_LOAD; en = 1; d = 8'h12; rst = 1;
    @(posedge clk); #1;
    chk("rst_beats_load", q8, 8'hA5);
    chk("rst_beats_load_q1", q1, 1'b0);
    rst = 0;
    step(MODE_SHR, 1, 8'h00, 1, 0);
    chk("w1_shr_q", q1, 1'b1);
    chk("w1_shr_so", {som1, sol1}, 2'b11);
    chk("shr_d2", q8, 8'hD2);
    step(MODE_ASR, 1, 8'h00, 0, 0);
    chk("w1_asr_hold", q1, 1'b1);
    step(MODE_SHL, 1, 8'h00, 1, 0);
    chk("w1_shl_q", q1, 1'b0);
    step(MODE_HOLD, 1, 8'h00, 1, 1);
    @(negedge clk);
    run = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
